lfsr_stream: RTL and testbench

LFSR_STREAM -- requirements
Module: lfsr_stream

---
 rtl/lfsr_stream.sv | 110 +++++++++++
 tb/tb_lfsr_stream.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR word source with a one-deep valid/ready output stage and an accepted-word counter.
// Optional zero-seed substitution is enabled by defining LFSR_STREAM_ZERO_GUARD_EN.
`timescale 1ns/1ps

module lfsr_stream #(
  parameter int unsigned      WIDTH        = 128,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'((256'd1 << 127) | (256'd1 << 125) |
                                                    (256'd1 << 100) | (256'd1 << 98)),
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  parameter int unsigned      CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             seeded,
  output logic             zero_seed_err
);

  typedef enum logic {
    IDLE,
    RUN
  } fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] seed_eff;
  logic             slot_free;
  logic             accept;

  if (WIDTH < 8 || WIDTH > 256) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be in 8..256");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_stream: STEP must be in 1..WIDTH");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_default
    $error("lfsr_stream: DEFAULT_SEED must be nonzero");
  end

  // STEP single shifts unrolled into one combinational cone.
  always_comb begin
    adv = lfsr;
    for (int unsigned i = 0; i < STEP; i++) begin
      adv = {adv[WIDTH-2:0], ^(adv & TAPS)};
    end
  end

`ifdef LFSR_STREAM_ZERO_GUARD_EN
  logic zero_hit;

  always_comb begin
    zero_hit = (seed == '0);
    seed_eff = zero_hit ? DEFAULT_SEED : seed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_seed_err <= 1'b0;
    end else begin
      zero_seed_err <= load_seed && zero_hit;
    end
  end
`else
  always_comb begin
    seed_eff = seed;
  end

  assign zero_seed_err = 1'b0;
`endif

  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;
  assign seeded    = (fsm == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      lfsr      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else if (load_seed) begin
      // Seed load overrides any advance or transfer in the same cycle.
      fsm       <= RUN;
      lfsr      <= seed_eff;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else if (fsm == RUN) begin
      if (accept) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (slot_free && enable) begin
        lfsr      <= adv;
        out_data  <= adv;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: WIDTH=8, TAPS bits 7,5,4,3, with STEP=1, STEP=4 and CNT_W=4 instances.
`timescale 1ns/1ps

module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load_seed;
  logic [7:0] seed;
  logic       out_ready;

  logic [7:0]  d1, d4, dc;
  logic        v1, v4, vc;
  logic [31:0] c1, c4;
  logic [3:0]  cc;
  logic        s1, s4, sc;
  logic        z1, z4, zc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .STEP(1), .DEFAULT_SEED(8'h01), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .load_seed(load_seed), .seed(seed),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready), .word_cnt(c1),
    .seeded(s1), .zero_seed_err(z1)
  );

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .STEP(4), .DEFAULT_SEED(8'h01), .CNT_W(32)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .load_seed(load_seed), .seed(seed),
    .out_data(d4), .out_valid(v4), .out_ready(out_ready), .word_cnt(c4),
    .seeded(s4), .zero_seed_err(z4)
  );

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .STEP(1), .DEFAULT_SEED(8'h01), .CNT_W(4)) uc (
    .clk(clk), .reset(reset), .enable(enable), .load_seed(load_seed), .seed(seed),
    .out_data(dc), .out_valid(vc), .out_ready(out_ready), .word_cnt(cc),
    .seeded(sc), .zero_seed_err(zc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the STEP=1, CNT_W=32 instance in one call.
  task automatic chk1(input string tag, input logic [7:0] d, input logic v, input logic [31:0] c);
    chk({tag, ".data"}, 32'(d1), 32'(d));
    chk({tag, ".valid"}, 32'(v1), 32'(v));
    chk({tag, ".cnt"}, c1, c);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load_seed = 1'b0; seed = 8'h00; out_ready = 1'b0;
    tick(); tick();
    chk1("reset", 8'h00, 1'b0, 32'd0);
    chk("reset.seeded", 32'(s1), 32'd0);
    chk("reset.zerr", 32'(z1), 32'd0);

    // IDLE ignores enable/out_ready
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    tick(); tick();
    chk1("idle", 8'h00, 1'b0, 32'd0);
    chk("idle.seeded", 32'(s1), 32'd0);

    // Seed 01, stream with enable/out_ready high
    load_seed = 1'b1; seed = 8'h01;
    tick();
    chk1("load", 8'h00, 1'b0, 32'd0);
    chk("load.seeded", 32'(s1), 32'd1);
    load_seed = 1'b0;
    tick();
    chk1("w1", 8'h02, 1'b1, 32'd0);
    chk("step4.data", 32'(d4), 32'h11);
    chk("step4.valid", 32'(v4), 32'd1);
    tick(); chk1("w2", 8'h04, 1'b1, 32'd1);
    tick(); chk1("w3", 8'h08, 1'b1, 32'd2);
    tick(); chk1("w4", 8'h11, 1'b1, 32'd3);
    tick(); chk1("w5", 8'h23, 1'b1, 32'd4);

    // Reload concurrent with an accepted transfer
    load_seed = 1'b1; seed = 8'h01;
    tick();
    chk("reload.valid", 32'(v1), 32'd0);
    chk("reload.cnt", c1, 32'd0);
    chk("reload.cntc", 32'(cc), 32'd0);
    load_seed = 1'b0;
    tick(); chk1("b1", 8'h02, 1'b1, 32'd0);
    tick(); chk1("b2", 8'h04, 1'b1, 32'd1);

    // Backpressure: 04 held for 5 cycles despite enable
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("hold", 8'h04, 1'b1, 32'd1);
    end
    out_ready = 1'b1;
    tick(); chk1("release", 8'h08, 1'b1, 32'd2);

    // Counter wrap on the CNT_W=4 instance
    repeat (13) tick();
    chk("wrap.pre", 32'(cc), 32'd15);
    tick();
    chk("wrap.cntc", 32'(cc), 32'd0);
    chk("wrap.cnt1", c1, 32'd16);

    // Idle cycle with out_ready high drops valid without advancing
    enable = 1'b0;
    tick();
    chk("drain.valid", 32'(v1), 32'd0);
    enable = 1'b1;

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk1("areset", 8'h00, 1'b0, 32'd0);
    chk("areset.seeded", 32'(s1), 32'd0);
    chk("areset.cntc", 32'(cc), 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk1("post_reset", 8'h00, 1'b0, 32'd0);
    chk("post_reset.seeded", 32'(s1), 32'd0);

    // Zero seed
    load_seed = 1'b1; seed = 8'h00;
    tick();
`ifdef LFSR_STREAM_ZERO_GUARD_EN
    chk("zero.err", 32'(z1), 32'd1);
`else
    chk("zero.err", 32'(z1), 32'd0);
`endif
    load_seed = 1'b0;
    tick();
    chk("zero.err_off", 32'(z1), 32'd0);
`ifdef LFSR_STREAM_ZERO_GUARD_EN
    chk1("zero.w1", 8'h02, 1'b1, 32'd0);
    tick(); chk1("zero.w2", 8'h04, 1'b1, 32'd1);
`else
    chk1("zero.w1", 8'h00, 1'b1, 32'd0);
    tick(); chk1("zero.w2", 8'h00, 1'b1, 32'd1);
`endif
    chk("zero.err_end", 32'(z1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
